ship_placer: RTL
================

SHIP_PLACER -- requirements
Module: ship_placer

Interface
REQ-001 The block SHALL have parameter BOARD_N, default 5, meaning the board edge length in cells.
REQ-002 The block SHALL have parameter MAX_SHIPS, default 5, meaning the ceiling applied to the requested ship count.
REQ-003 The block SHALL have port clk, input, width 1, the single clock.
REQ-004 The block SHALL have port rst, input, width 1, asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, width 1, a level that opens a placement session on its rising edge.
REQ-006 The block SHALL have ports move_up, move_down, move_left and move_right, each input, width 1, button levels for cursor moves.
REQ-007 The block SHALL have port place, input, width 1, a button level requesting a ship at the cursor.
REQ-008 The block SHALL have port amount_of_ships, input, width 3, the requested ship count.
REQ-009 The block SHALL have ports cursor_i and cursor_j, each output, width 3, the cursor row and column.
REQ-010 The block SHALL have port board, output, width 2*BOARD_N*BOARD_N, the flattened cells; cell (i,j) is at bits [2*(i*BOARD_N+j) +: 2].
REQ-011 The block SHALL have port ships_placed, output, width 3, the number of ships placed this session.
REQ-012 The block SHALL have port ships_remaining, output, width 3, equal to target minus ships_placed.
REQ-013 The block SHALL have port placing, output, width 1, high while in PLACE.
REQ-014 The block SHALL have port done, output, width 1, high while in DONE.
REQ-015 The block SHALL have port reject, output, width 1, a one-cycle pulse when a place request lands on an occupied cell.

Function
REQ-016 All buttons SHALL be rising-edge detected against a registered previous sample; held buttons SHALL act once.
REQ-017 The FSM SHALL have states IDLE, PLACE and DONE.
REQ-018 On a start edge in IDLE or DONE: board cleared to WATER, cursor set to (0,0), ships_placed 0, target latched as min(amount_of_ships, MAX_SHIPS), next state PLACE, or DONE if target is 0.
REQ-019 A start edge in PLACE SHALL be ignored.
REQ-020 Moves: up decrements i, down increments i, left decrements j, right increments j; each saturates at 0 and BOARD_N-1, with no wrap.
REQ-021 Simultaneous move edges SHALL apply only the highest-priority one, in the order up > down > left > right.
REQ-022 A place edge in PLACE on a WATER cell SHALL write SHIP and increment ships_placed at the same clock edge at which the place edge is detected.
REQ-023 A place edge on a SHIP cell SHALL leave the board and count unchanged and pulse reject for exactly one cycle.
REQ-024 The placement that makes ships_placed equal target SHALL move the FSM to DONE at that same edge.
REQ-025 When place and move edges coincide, placement SHALL use the pre-move cursor and the move SHALL also apply.
REQ-026 Moves and place requests outside PLACE SHALL be ignored, with no reject.
REQ-027 DONE SHALL hold board, ships_placed and cursor stable until the next start edge.
REQ-028 Changes on amount_of_ships after the target is latched SHALL have no effect.

Reset
REQ-029 Reset SHALL force: state IDLE, board all WATER, cursor (0,0), ships_placed 0, target 0, ships_remaining 0, placing 0, done 0, reject 0, all edge-detect registers 0.
REQ-030 Reset asserted mid-session SHALL abort the session immediately, with no partial state retained.

Structure
REQ-031 Shared package battleship_pkg SHALL hold cell_t (WATER=00, SHIP=01, HIT=10, MISS=11), the FSM state enum and BOARD_N.
REQ-032 The block SHALL use one sub-module, edge_detect, instantiated once per button (6 instances).

Verification
REQ-033 Test 1: amount_of_ships=3, start, place at (0,0), right, place, down, place -> cells (0,0), (0,1) and (1,1) are SHIP, ships_placed=3, done=1, ships_remaining=0.
REQ-034 Test 2: at (0,0), press up and then left 3 times each -> cursor stays at (0,0); at (4,4), press down and then right -> cursor stays at (4,4).
REQ-035 Test 3: place twice at (2,2) -> one SHIP, ships_placed=1, one reject pulse lasting 1 cycle.
REQ-036 Test 4: amount_of_ships=7 -> target 5; amount_of_ships=0 -> done=1 with the board all WATER.
REQ-037 Test 5: up+right asserted together from (2,2) -> cursor (1,2); place held for 10 cycles -> one placement.
REQ-038 Test 6: assert rst after 2 placements -> board all WATER, state IDLE, ships_placed=0, asynchronously before the next clk edge.

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared battleship types: cell encoding, placer FSM states and button slots.
package battleship_pkg;

    localparam int BOARD_N = 5;

    typedef enum logic [1:0] {
        WATER = 2'b00,
        SHIP  = 2'b01,
        HIT   = 2'b10,
        MISS  = 2'b11
    } cell_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLACE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Slot of each button in the edge-detect vector
    localparam int NUM_BTN = 6;
    localparam int B_UP    = 0;
    localparam int B_DOWN  = 1;
    localparam int B_LEFT  = 2;
    localparam int B_RIGHT = 3;
    localparam int B_PLACE = 4;
    localparam int B_START = 5;

    function automatic logic [2:0] clamp_ships(input logic [2:0] req, input int max_ships);
        if (int'(req) > max_ships) return 3'(max_ships);
        return req;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for one button level against its registered previous sample.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= 1'b0;
        else     prev <= btn;
    end

    assign rise = btn & ~prev;

endmodule

// File: rtl/ship_placer.sv
// Ship placement session: cursor moves over the board and drops ships on water
// cells until the latched target count is reached.
module ship_placer #(
    parameter int BOARD_N   = battleship_pkg::BOARD_N,
    parameter int MAX_SHIPS = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         move_up,
    input  logic                         move_down,
    input  logic                         move_left,
    input  logic                         move_right,
    input  logic                         place,
    input  logic [2:0]                   amount_of_ships,
    output logic [2:0]                   cursor_i,
    output logic [2:0]                   cursor_j,
    output logic [2*BOARD_N*BOARD_N-1:0] board,
    output logic [2:0]                   ships_placed,
    output logic [2:0]                   ships_remaining,
    output logic                         placing,
    output logic                         done,
    output logic                         reject
);
    import battleship_pkg::*;

    localparam int CELLS = BOARD_N * BOARD_N;
    localparam int IDXW  = $clog2(CELLS);
    localparam logic [2:0] EDGE_MAX = 3'(BOARD_N - 1);

    logic [NUM_BTN-1:0] btn_lvl, btn_rise;
    cell_t [CELLS-1:0]  cells;
    state_t             state;
    logic [2:0]         ci, cj, placed, target, start_target;
    logic [IDXW-1:0]    cur_idx;

    assign btn_lvl = {start, place, move_right, move_left, move_down, move_up};

    edge_detect u_edge [NUM_BTN-1:0] (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_lvl),
        .rise (btn_rise)
    );

    assign start_target = clamp_ships(amount_of_ships, MAX_SHIPS);
    assign cur_idx      = IDXW'(int'(ci) * BOARD_N + int'(cj));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            for (int k = 0; k < CELLS; k++) cells[k] <= WATER;
            ci     <= '0;
            cj     <= '0;
            placed <= '0;
            target <= '0;
            reject <= 1'b0;
        end else begin
            reject <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (btn_rise[B_START]) begin
                        for (int k = 0; k < CELLS; k++) cells[k] <= WATER;
                        ci     <= '0;
                        cj     <= '0;
                        placed <= '0;
                        target <= start_target;
                        state  <= (start_target == 3'd0) ? S_DONE : S_PLACE;
                    end
                end
                S_PLACE: begin
                    // Placement uses the pre-move cursor; a coincident move still lands
                    if (btn_rise[B_PLACE]) begin
                        if (cells[cur_idx] == WATER) begin
                            cells[cur_idx] <= SHIP;
                            placed         <= placed + 3'd1;
                            if (placed + 3'd1 == target) state <= S_DONE;
                        end else begin
                            reject <= 1'b1;
                        end
                    end
                    if (btn_rise[B_UP]) begin
                        if (ci != 3'd0) ci <= ci - 3'd1;
                    end else if (btn_rise[B_DOWN]) begin
                        if (ci != EDGE_MAX) ci <= ci + 3'd1;
                    end else if (btn_rise[B_LEFT]) begin
                        if (cj != 3'd0) cj <= cj - 3'd1;
                    end else if (btn_rise[B_RIGHT]) begin
                        if (cj != EDGE_MAX) cj <= cj + 3'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign board           = cells;
    assign cursor_i        = ci;
    assign cursor_j        = cj;
    assign ships_placed    = placed;
    assign ships_remaining = target - placed;
    assign placing         = (state == S_PLACE);
    assign done            = (state == S_DONE);

endmodule
